// File: rtl/decimator_mc.sv
// Multichannel runtime-configurable decimator (pick / boxcar-sum) with a registered AXI-Stream output.
// Optional tag sequence checking is enabled by defining DECIM_SEQ_CHECK_EN (adds the seq_err port).
module decimator_mc #(
  parameter int DATA_W    = 24,
  parameter int CHAN_W    = 2,
  parameter int MAX_RATIO = 16,
  parameter int RATIO_W   = $clog2(MAX_RATIO) + 1,
  parameter int OUT_W     = DATA_W + $clog2(MAX_RATIO)
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_areset,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               cfg_mode,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [CHAN_W-1:0]  s_axis_tuser,
  output logic [OUT_W-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [CHAN_W-1:0]  m_axis_tuser
`ifdef DECIM_SEQ_CHECK_EN
  ,
  output logic               seq_err
`endif
);

  localparam int NUM_CH = 2 ** CHAN_W;

  logic [RATIO_W-1:0] cnt [NUM_CH];
  logic [OUT_W-1:0]   acc [NUM_CH];
  logic [RATIO_W-1:0] re_eff, re_q;
  logic               mode_q;

  logic               accept, cfg_change, clear_all, last, produce;
  logic [RATIO_W-1:0] cur_cnt, cnt_nxt;
  logic [OUT_W-1:0]   sample_ext, acc_nxt, out_nxt;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign sample_ext    = {{(OUT_W-DATA_W){s_axis_tdata[DATA_W-1]}}, s_axis_tdata};

  always_comb begin
    re_eff = cfg_ratio;
    if (cfg_ratio == '0)
      re_eff = RATIO_W'(1);
    else if (cfg_ratio > RATIO_W'(MAX_RATIO))
      re_eff = RATIO_W'(MAX_RATIO);
  end

  assign cfg_change = (cfg_mode != mode_q) || (re_eff != re_q);

`ifdef DECIM_SEQ_CHECK_EN
  logic [CHAN_W-1:0] exp_tag;
  logic              seq_bad;

  assign seq_bad   = accept && (s_axis_tuser != exp_tag);
  assign clear_all = cfg_change || seq_bad;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      exp_tag <= '0;
      seq_err <= 1'b0;
    end else if (accept) begin
      exp_tag <= s_axis_tuser + CHAN_W'(1);
      if (seq_bad)
        seq_err <= 1'b1;
    end
  end
`else
  assign clear_all = cfg_change;
`endif

  // A clear in the same cycle makes the incoming sample the first of a new group.
  always_comb begin
    cur_cnt = clear_all ? '0 : cnt[s_axis_tuser];
    last    = (cur_cnt == re_eff - RATIO_W'(1));
    cnt_nxt = last ? '0 : cur_cnt + RATIO_W'(1);
    acc_nxt = (cur_cnt == '0) ? sample_ext : acc[s_axis_tuser] + sample_ext;
    produce = cfg_mode ? last : (cur_cnt == '0);
    out_nxt = cfg_mode ? acc_nxt : sample_ext;
  end

  // NOTE: the per-channel arrays are tiny register files, so they are reset
  // explicitly; a stale count or partial sum must never leak out of reset.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      mode_q <= cfg_mode;
      re_q   <= re_eff;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      if (cfg_change) begin
        mode_q <= cfg_mode;
        re_q   <= re_eff;
      end
      if (clear_all) begin
        for (int i = 0; i < NUM_CH; i++) begin
          cnt[i] <= '0;
          acc[i] <= '0;
        end
      end
      // NOTE: non-blocking assignments let this later per-channel update win
      // over the bulk clear above without any ordering hazard.
      if (accept) begin
        cnt[s_axis_tuser] <= cnt_nxt;
        acc[s_axis_tuser] <= acc_nxt;
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else if (accept && produce) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= out_nxt;
      m_axis_tuser  <= s_axis_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decimator_mc.sv
// Randomised self-checking bench for decimator_mc against a group-based reference model.
// Define DECIM_SEQ_CHECK_EN for both files to also exercise the tag sequence checker.
module tb_decimator_mc;

  localparam int DATA_W    = 24;
  localparam int CHAN_W    = 2;
  localparam int MAX_RATIO = 16;
  localparam int RATIO_W   = $clog2(MAX_RATIO) + 1;
  localparam int OUT_W     = DATA_W + $clog2(MAX_RATIO);
  localparam int NUM_CH    = 2 ** CHAN_W;

  logic               s_axis_aclk = 1'b0;
  logic               s_axis_areset;
  logic [RATIO_W-1:0] cfg_ratio;
  logic               cfg_mode;
  logic [DATA_W-1:0]  s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [CHAN_W-1:0]  s_axis_tuser;
  logic [OUT_W-1:0]   m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [CHAN_W-1:0]  m_axis_tuser;
`ifdef DECIM_SEQ_CHECK_EN
  logic               seq_err;
`endif

  decimator_mc #(
    .DATA_W(DATA_W), .CHAN_W(CHAN_W), .MAX_RATIO(MAX_RATIO),
    .RATIO_W(RATIO_W), .OUT_W(OUT_W)
  ) dut (
    .s_axis_aclk   (s_axis_aclk),
    .s_axis_areset (s_axis_areset),
    .cfg_ratio     (cfg_ratio),
    .cfg_mode      (cfg_mode),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser)
`ifdef DECIM_SEQ_CHECK_EN
    ,
    .seq_err       (seq_err)
`endif
  );

  always #5 s_axis_aclk = ~s_axis_aclk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: each channel holds the samples of its current group;
  // expected outputs queue up in the order they must appear on the master side.
  typedef struct {
    logic [OUT_W-1:0]  data;
    logic [CHAN_W-1:0] user;
  } out_t;

  longint            grp [NUM_CH][$];
  out_t              exp_q[$];
  int                prev_re;
  logic              prev_mode;
  logic              m_seq_err;
  logic [CHAN_W-1:0] m_exp_tag;

  function automatic int re_of(input int r);
    if (r == 0) return 1;
    if (r > MAX_RATIO) return MAX_RATIO;
    return r;
  endfunction

  task automatic clear_groups();
    for (int c = 0; c < NUM_CH; c++) grp[c].delete();
  endtask

  task automatic model_step();
    logic   ready;
    int     re;
    longint sum;
    out_t   o;
    if (s_axis_areset) begin
      clear_groups();
      exp_q.delete();
      prev_re   = re_of(int'(cfg_ratio));
      prev_mode = cfg_mode;
      m_seq_err = 1'b0;
      m_exp_tag = '0;
      return;
    end
    check("m_tvalid", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
    check("s_tready", 64'(s_axis_tready), 64'((exp_q.size() == 0) || m_axis_tready));
    if (exp_q.size() != 0) begin
      check("m_tdata", 64'(m_axis_tdata), 64'(exp_q[0].data));
      check("m_tuser", 64'(m_axis_tuser), 64'(exp_q[0].user));
    end
`ifdef DECIM_SEQ_CHECK_EN
    check("seq_err", 64'(seq_err), 64'(m_seq_err));
`endif
    ready = (exp_q.size() == 0) || m_axis_tready;
    if (exp_q.size() != 0 && m_axis_tready) void'(exp_q.pop_front());
    re = re_of(int'(cfg_ratio));
    if (re != prev_re || cfg_mode != prev_mode) begin
      clear_groups();
      prev_re   = re;
      prev_mode = cfg_mode;
    end
    if (s_axis_tvalid && ready) begin
`ifdef DECIM_SEQ_CHECK_EN
      if (s_axis_tuser != m_exp_tag) begin
        m_seq_err = 1'b1;
        clear_groups();
      end
      m_exp_tag = s_axis_tuser + CHAN_W'(1);
`endif
      grp[s_axis_tuser].push_back(longint'($signed(s_axis_tdata)));
      if (!cfg_mode && grp[s_axis_tuser].size() == 1) begin
        o.data = OUT_W'(grp[s_axis_tuser][0]);
        o.user = s_axis_tuser;
        exp_q.push_back(o);
      end
      if (grp[s_axis_tuser].size() == re) begin
        if (cfg_mode) begin
          sum = 0;
          foreach (grp[s_axis_tuser][k]) sum += grp[s_axis_tuser][k];
          o.data = OUT_W'(sum);
          o.user = s_axis_tuser;
          exp_q.push_back(o);
        end
        grp[s_axis_tuser].delete();
      end
    end
  endtask

  // One clock: drive inputs just after the edge, model and check at the falling edge.
  task automatic cyc(input logic v, input logic [CHAN_W-1:0] tag,
                     input logic [DATA_W-1:0] d, input logic mr);
    s_axis_tvalid = v;
    s_axis_tuser  = tag;
    s_axis_tdata  = d;
    m_axis_tready = mr;
    @(negedge s_axis_aclk);
    model_step();
    @(posedge s_axis_aclk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    s_axis_areset = 1'b1;
    cfg_ratio     = RATIO_W'(5);
    cfg_mode      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    #1;
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    s_axis_areset = 1'b0;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check("rst_tuser", 64'(m_axis_tuser), 64'(0));

    // Pick, R=5, channel 0 ramp.
    for (int i = 0; i < 15; i++) cyc(1'b1, 2'd0, DATA_W'(i), 1'b1);
    drain();

    // Sum, R=4, interleaved positive and negative channels.
    cfg_mode  = 1'b1;
    cfg_ratio = RATIO_W'(4);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 2'd0, DATA_W'(100), 1'b1);
      cyc(1'b1, 2'd1, DATA_W'(-3), 1'b1);
    end
    drain();

    // Sum, R=16, full-scale positive on channel 2.
    cfg_ratio = RATIO_W'(16);
    for (int i = 0; i < 16; i++) cyc(1'b1, 2'd2, 24'h7FFFFF, 1'b1);
    drain();

    // Backpressure in passthrough.
    cfg_mode  = 1'b0;
    cfg_ratio = RATIO_W'(1);
    cyc(1'b1, 2'd0, 24'h000AAA, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 24'h000BBB, 1'b0);
    cyc(1'b1, 2'd0, 24'h000BBB, 1'b1);
    drain();

    // Mid-group config change discards the partial group.
    cfg_mode  = 1'b1;
    cfg_ratio = RATIO_W'(4);
    cyc(1'b1, 2'd0, DATA_W'(7), 1'b1);
    cyc(1'b1, 2'd0, DATA_W'(9), 1'b1);
    cfg_ratio = RATIO_W'(2);
    cyc(1'b1, 2'd0, DATA_W'(10), 1'b1);
    cyc(1'b1, 2'd0, DATA_W'(20), 1'b1);
    drain();

    // Ratio clamping: 0 acts as 1, 31 acts as 16.
    cfg_ratio = RATIO_W'(0);
    for (int i = 0; i < 4; i++) cyc(1'b1, CHAN_W'(i), DATA_W'(i * 3 - 5), 1'b1);
    cfg_ratio = RATIO_W'(31);
    for (int i = 0; i < 16; i++) cyc(1'b1, 2'd3, DATA_W'(i - 8), 1'b1);
    drain();

    // Randomised traffic with occasional reconfiguration and backpressure.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cfg_ratio = RATIO_W'($urandom_range(0, 31));
        cfg_mode  = 1'($urandom_range(0, 1));
      end
      cyc(1'($urandom_range(0, 9) < 7), CHAN_W'($urandom), DATA_W'($urandom),
          1'($urandom_range(0, 3) != 0));
    end
    drain();

`ifdef DECIM_SEQ_CHECK_EN
    s_axis_areset = 1'b1;
    cfg_mode      = 1'b0;
    cfg_ratio     = RATIO_W'(2);
    cyc(1'b0, '0, '0, 1'b1);
    s_axis_areset = 1'b0;
    cyc(1'b1, 2'd0, DATA_W'(1), 1'b1);
    cyc(1'b1, 2'd1, DATA_W'(2), 1'b1);
    cyc(1'b1, 2'd3, DATA_W'(3), 1'b1);
    cyc(1'b1, 2'd0, DATA_W'(4), 1'b1);
    drain();
    check("seq_err_sticky", 64'(seq_err), 64'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
